axi4_lite_master: RTL
=====================

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI data width (32 or 64); strobe width DATA_WIDTH/8.
REQ-003 SHALL have ports, clock and reset first:
 i_clock  in  1  single clock, all logic on rising edge
 i_areset_n  in  1  asynchronous active-low reset
 i_cmd_valid/o_cmd_ready  in/out  1  command handshake
 i_cmd_write  in  1  1=write, 0=read
 i_cmd_addr  in  ADDR_WIDTH  byte address
 i_cmd_wdata/i_cmd_wstrb  in  DATA_WIDTH, DATA_WIDTH/8  write payload
 o_rsp_valid/i_rsp_ready  out/in  1  response handshake
 o_rsp_write  out  1  response belongs to write
 o_rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
 o_rsp_resp  out  2  BRESP/RRESP
 o_awaddr, o_awprot[3], o_awvalid / i_awready  AW channel
 o_wdata, o_wstrb, o_wvalid / i_wready  W channel
 i_bresp[2], i_bvalid / o_bready  B channel
 o_araddr, o_arprot[3], o_arvalid / i_arready  AR channel
 i_rdata, i_rresp[2], i_rvalid / o_rready  R channel

Function
REQ-004 SHALL be an AXI4-Lite initiator, one outstanding transaction, no reordering.
REQ-005 SHALL use states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
REQ-006 IDLE: command accepted on i_cmd_valid & o_cmd_ready; write -> WR_REQ, read -> RD_REQ; addr/data/strb registered.
REQ-007 WR_REQ: o_awvalid and o_wvalid asserted from cycle after acceptance; each deasserts the cycle after its own handshake; AW and W handshakes in any order or same cycle; -> WR_RESP when both complete.
REQ-008 WR_RESP: o_bready=1; on i_bvalid capture i_bresp, o_rsp_rdata=0, o_rsp_write=1, -> RSP.
REQ-009 RD_REQ: o_arvalid=1 until i_arready; -> RD_RESP. RD_RESP: o_rready=1; on i_rvalid capture i_rdata/i_rresp, o_rsp_write=0, -> RSP.
REQ-010 o_bready SHALL be 0 outside WR_RESP; o_rready 0 outside RD_RESP; early i_bvalid/i_rvalid held off.
REQ-011 RSP: o_rsp_valid=1, payload stable until i_rsp_ready; -> IDLE next cycle.
REQ-012 AXI address/data/strobe outputs SHALL be registered and stable while corresponding valid is high; o_awprot=o_arprot=3'b000.
REQ-013 Latency with always-ready slave: command accepted cycle N, AXI valid N+1, o_rsp_valid N+3.
REQ-014 SLVERR/DECERR SHALL be passed to o_rsp_resp unchanged; no retry.

Reset
REQ-015 On i_areset_n=0 SHALL immediately enter IDLE; all valid/ready outputs 0 except o_cmd_ready (0 in reset, 1 first cycle after); data/resp outputs 0.
REQ-016 Reset mid-transaction SHALL abandon it without a response; no AXI valid after release until new command.

Configuration
REQ-017 AXI4_LITE_MASTER_CMD_SKID_EN defined: command input passes through a registered skid stage; o_cmd_ready registered, one extra command buffered while busy, accepted-to-valid latency unchanged when idle.
REQ-018 Macro undefined: o_cmd_ready = (state==IDLE) combinationally, no buffering.

Structure
REQ-019 Package axi4_lite_pkg SHALL hold response codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11, default PROT 3'b000, and state encoding.
REQ-020 Skid stage SHALL instantiate existing sub-module skid_buffer with DWIDTH = 1+ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8.

Verification
REQ-021 Write addr 0x10, data 0xDEADBEEF, strb 0xF, slave always ready, bresp OKAY -> AW/W valid cycle N+1, o_rsp_valid N+3, resp 2'b00, write=1.
REQ-022 Write with i_wready 3 cycles before i_awready -> o_wvalid drops after its handshake, o_awvalid held, o_bready only after both; single response.
REQ-023 Read 0x20, slave returns 0x12345678 rresp SLVERR after 4-cycle delay -> o_rsp_rdata=0x12345678, o_rsp_resp=2'b10.
REQ-024 i_rsp_ready low 5 cycles in RSP -> payload stable, o_cmd_ready 0 (no skid) throughout, new command only after drain.
REQ-025 Reset asserted while o_arvalid high -> o_arvalid 0 same cycle, no response after release, next read completes normally.
REQ-026 With AXI4_LITE_MASTER_CMD_SKID_EN: two back-to-back commands -> both accepted, AXI transactions and responses in order.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg
//   Shared definitions for the AXI4-Lite initiator: response codes, the
//   protection value driven on AxPROT, and the controller state encoding.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

endpackage

// File: rtl/skid_buffer.sv
// skid_buffer
//   Valid/ready pipeline stage with a registered upstream ready. When empty
//   the data passes straight through (no added latency); when downstream
//   stalls, one beat is parked in an internal register.
// Ports:
//   i_clock, i_areset_n     clock, asynchronous active-low reset
//   i_valid/o_ready/i_data  upstream handshake and payload
//   o_valid/i_ready/o_data  downstream handshake and payload
module skid_buffer #(
  parameter int DWIDTH = 8
) (
  input  logic              i_clock,
  input  logic              i_areset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DWIDTH-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DWIDTH-1:0] o_data
);

  logic              full_q;
  logic              full_d;
  logic              ready_q;
  logic [DWIDTH-1:0] buf_q;
  logic              in_fire;

  // ready_q is 0 while in reset, so nothing is accepted until it rises.
  assign in_fire = i_valid & ready_q;
  assign o_valid = full_q | in_fire;
  assign o_data  = full_q ? buf_q : i_data;
  assign o_ready = ready_q;

  always_comb begin
    full_d = full_q;
    if (full_q) begin
      if (i_ready) full_d = 1'b0;
    end else if (in_fire && !i_ready) begin
      full_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_areset_n) begin
    if (!i_areset_n) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      full_q  <= full_d;
      ready_q <= !full_d;
    end
  end

  // NOTE: the parked payload has no reset; it is only observed while full_q
  // is set, and full_q is reset, so resetting the data would just cost flops.
  always_ff @(posedge i_clock) begin
    if (!full_q && in_fire && !i_ready) buf_q <= i_data;
  end

endmodule

// File: rtl/axi4_lite_master.sv
// axi4_lite_master
//   AXI4-Lite initiator: takes one command (read or write) at a time on a
//   valid/ready command port, runs it on the AXI channels and returns the
//   response on a valid/ready response port. One outstanding transaction.
// Ports:
//   i_clock, i_areset_n                      clock, async active-low reset
//   i_cmd_valid/o_cmd_ready, i_cmd_write,
//   i_cmd_addr, i_cmd_wdata, i_cmd_wstrb     command port
//   o_rsp_valid/i_rsp_ready, o_rsp_write,
//   o_rsp_rdata, o_rsp_resp                  response port
//   AW, W, B, AR, R channels                 AXI4-Lite master interface
// Configuration:
//   AXI4_LITE_MASTER_CMD_SKID_EN  when defined, commands enter through a
//   skid_buffer (registered o_cmd_ready, one command buffered while busy).
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    i_clock,
  input  logic                    i_areset_n,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic                    o_rsp_write,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]              o_rsp_resp,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  output logic [2:0]              o_awprot,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [DATA_WIDTH/8-1:0] o_wstrb,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  input  logic [1:0]              i_bresp,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  output logic [2:0]              o_arprot,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  input  logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic [1:0]              i_rresp,
  input  logic                    i_rvalid,
  output logic                    o_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;

  state_t state_q, state_d;

  // Command as seen by the controller (after the optional skid stage).
  logic                  c_valid;
  logic                  c_ready;
  logic                  c_write;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [STRB_W-1:0]     c_wstrb;
  logic                  cmd_fire;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  aw_done_q;
  logic                  w_done_q;
  logic                  aw_fire;
  logic                  w_fire;
  logic                  rsp_write_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]            rsp_resp_q;

  assign c_ready  = (state_q == IDLE);
  assign cmd_fire = c_valid & c_ready;

`ifdef AXI4_LITE_MASTER_CMD_SKID_EN
  localparam int CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_W;
  logic [CMD_W-1:0] c_bus;

  skid_buffer #(.DWIDTH(CMD_W)) u_cmd_skid (
    .i_clock    (i_clock),
    .i_areset_n (i_areset_n),
    .i_valid    (i_cmd_valid),
    .o_ready    (o_cmd_ready),
    .i_data     ({i_cmd_write, i_cmd_addr, i_cmd_wdata, i_cmd_wstrb}),
    .o_valid    (c_valid),
    .i_ready    (c_ready),
    .o_data     (c_bus)
  );

  assign {c_write, c_addr, c_wdata, c_wstrb} = c_bus;
`else
  // Holds o_cmd_ready low while in reset even though the state is IDLE.
  logic live_q;

  always_ff @(posedge i_clock or negedge i_areset_n) begin
    if (!i_areset_n) live_q <= 1'b0;
    else             live_q <= 1'b1;
  end

  assign o_cmd_ready = live_q & (state_q == IDLE);
  assign c_valid     = i_cmd_valid & live_q;
  assign c_write     = i_cmd_write;
  assign c_addr      = i_cmd_addr;
  assign c_wdata     = i_cmd_wdata;
  assign c_wstrb     = i_cmd_wstrb;
`endif

  // AXI valids/readies decode straight from registered state, so an
  // asynchronous reset drops them in the same cycle.
  assign o_awvalid = (state_q == WR_REQ) & ~aw_done_q;
  assign o_wvalid  = (state_q == WR_REQ) & ~w_done_q;
  assign o_bready  = (state_q == WR_RESP);
  assign o_arvalid = (state_q == RD_REQ);
  assign o_rready  = (state_q == RD_RESP);
  assign aw_fire   = o_awvalid & i_awready;
  assign w_fire    = o_wvalid & i_wready;

  assign o_awaddr  = addr_q;
  assign o_araddr  = addr_q;
  assign o_awprot  = PROT_DEFAULT;
  assign o_arprot  = PROT_DEFAULT;
  assign o_wdata   = wdata_q;
  assign o_wstrb   = wstrb_q;

  assign o_rsp_valid = (state_q == RSP);
  assign o_rsp_write = rsp_write_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_resp  = rsp_resp_q;

  // NOTE: state_d gets its hold value before the case so every path assigns
  // it; a missing branch would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire) state_d = c_write ? WR_REQ : RD_REQ;
      WR_REQ:  if ((aw_done_q | aw_fire) & (w_done_q | w_fire)) state_d = WR_RESP;
      WR_RESP: if (i_bvalid) state_d = RSP;
      RD_REQ:  if (i_arready) state_d = RD_RESP;
      RD_RESP: if (i_rvalid) state_d = RSP;
      RSP:     if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state here updates with <= so every register samples the
  // pre-edge values; blocking = would let later statements see new values.
  always_ff @(posedge i_clock or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      if (cmd_fire) begin
        addr_q    <= c_addr;
        wdata_q   <= c_wdata;
        wstrb_q   <= c_wstrb;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_fire) aw_done_q <= 1'b1;
        if (w_fire)  w_done_q  <= 1'b1;
      end
      if (state_q == WR_RESP && i_bvalid) begin
        rsp_write_q <= 1'b1;
        rsp_rdata_q <= '0;
        rsp_resp_q  <= i_bresp;
      end
      if (state_q == RD_RESP && i_rvalid) begin
        rsp_write_q <= 1'b0;
        rsp_rdata_q <= i_rdata;
        rsp_resp_q  <= i_rresp;
      end
    end
  end

endmodule
